// File: rtl/match_pe_order_scheduler_pkg.sv
// Shared sizing constants for the match PE order scheduler and its order queue.
package match_pe_order_scheduler_pkg;

  localparam int MATCH_PE_NUM      = 4;
  localparam int MATCH_PE_NUM_LOG2 = 2;
  localparam int JOB_SEQ_QUAD_W    = 256;
  localparam int PE_ORDER_DEPTH    = 16;
  localparam int PE_MAX_JOBS       = 2;

endpackage

// File: rtl/match_pe_order_queue.sv
// Synchronous FIFO recording launch order as {pe index, delim} entries.
module match_pe_order_queue
  import match_pe_order_scheduler_pkg::*;
#(
  parameter int ENTRY_W = MATCH_PE_NUM_LOG2 + 1,
  parameter int DEPTH   = PE_ORDER_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_pushData,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_headData,
  output logic               o_full,
  output logic               o_empty,
  output logic [PTR_W-1:0]   o_count
);

  localparam int ADDR_W = PTR_W - 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic               w_pushFire;
  logic               w_popFire;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign o_empty    = (r_wrPtr == r_rdPtr);
  assign o_full     = (r_wrPtr[ADDR_W-1:0] == r_rdPtr[ADDR_W-1:0]) &&
                      (r_wrPtr[ADDR_W] != r_rdPtr[ADDR_W]);
  assign o_count    = r_wrPtr - r_rdPtr;
  assign o_headData = r_mem[r_rdPtr[ADDR_W-1:0]];
  assign w_pushFire = i_push && !o_full;
  assign w_popFire  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_pushFire) begin
      r_mem[r_wrPtr[ADDR_W-1:0]] <= i_pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_pushFire) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popFire) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_pe_order_scheduler.sv
// Launches jobs to match PEs in strict round-robin order and merges their
// sequence FIFOs back in launch order using a recorded order queue.
module match_pe_order_scheduler #(
  parameter int PE_NUM      = match_pe_order_scheduler_pkg::MATCH_PE_NUM,
  parameter int PE_IDX_W    = match_pe_order_scheduler_pkg::MATCH_PE_NUM_LOG2,
  parameter int ORDER_DEPTH = match_pe_order_scheduler_pkg::PE_ORDER_DEPTH,
  parameter int PE_MAX_JOBS = match_pe_order_scheduler_pkg::PE_MAX_JOBS,
  parameter int SEQ_W       = match_pe_order_scheduler_pkg::JOB_SEQ_QUAD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_req_valid,
  input  logic                      job_req_delim,
  output logic                      job_req_ready,
  output logic [PE_NUM-1:0]         pe_launch_valid,
  output logic                      pe_launch_delim,
  input  logic [PE_NUM-1:0]         pe_launch_ready,
  input  logic [PE_NUM-1:0]         seq_in_valid,
  input  logic [PE_NUM*SEQ_W-1:0]   seq_in_quad,
  input  logic [PE_NUM-1:0]         seq_in_end_of_job,
  output logic [PE_NUM-1:0]         seq_in_ready,
  output logic                      seq_out_valid,
  output logic [SEQ_W-1:0]          seq_out_quad,
  output logic                      seq_out_delim,
  input  logic                      seq_out_ready,
  output logic [$clog2(ORDER_DEPTH):0] jobs_in_flight,
  output logic                      idle
);

  import match_pe_order_scheduler_pkg::*;

  localparam int PTR_W = $clog2(ORDER_DEPTH) + 1;
  localparam int CNT_W = $clog2(PE_MAX_JOBS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(PE_MAX_JOBS);

  logic [PE_IDX_W-1:0] r_launchPtr;
  logic [CNT_W-1:0]    r_outstanding [PE_NUM];
  logic                w_qFull;
  logic                w_qEmpty;
  logic [PTR_W-1:0]    w_qCount;
  logic [PE_IDX_W:0]   w_pushEntry;
  logic [PE_IDX_W:0]   w_headEntry;
  logic [PE_IDX_W-1:0] w_headPe;
  logic                w_headDelim;
  logic                w_canLaunch;
  logic                w_launchFire;
  logic                w_drainFire;
  logic                w_popFire;

  assign w_pushEntry = {r_launchPtr, job_req_delim};
  assign w_headPe    = w_headEntry[PE_IDX_W:1];
  assign w_headDelim = w_headEntry[0];

  match_pe_order_queue #(
    .ENTRY_W (PE_IDX_W + 1),
    .DEPTH   (ORDER_DEPTH)
  ) u_orderQueue (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_launchFire),
    .i_pushData (w_pushEntry),
    .i_pop      (w_popFire),
    .o_headData (w_headEntry),
    .o_full     (w_qFull),
    .o_empty    (w_qEmpty),
    .o_count    (w_qCount)
  );

  // Outputs are forced quiet while rst is high since registers still hold old state.
  always_comb begin
    pe_launch_valid = '0;
    w_canLaunch     = !w_qFull && (r_outstanding[r_launchPtr] < MAX_CNT);
    job_req_ready   = !rst && w_canLaunch && pe_launch_ready[r_launchPtr];
    if (!rst && job_req_valid && w_canLaunch) begin
      pe_launch_valid[r_launchPtr] = 1'b1;
    end
  end

  assign pe_launch_delim = job_req_delim;
  assign w_launchFire    = job_req_valid && job_req_ready;

  always_comb begin
    seq_in_ready = '0;
    if (!rst && !w_qEmpty && seq_out_ready) begin
      seq_in_ready[w_headPe] = 1'b1;
    end
    seq_out_valid = !rst && !w_qEmpty && seq_in_valid[w_headPe];
    seq_out_quad  = seq_in_quad[w_headPe*SEQ_W +: SEQ_W];
    seq_out_delim = w_headDelim && seq_in_end_of_job[w_headPe];
  end

  assign w_drainFire = seq_out_valid && seq_out_ready;
  assign w_popFire   = w_drainFire && seq_in_end_of_job[w_headPe];

  // A launch and an end-of-job drain on the same PE cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_launchPtr <= '0;
      for (int i = 0; i < PE_NUM; i++) begin
        r_outstanding[i] <= '0;
      end
    end else begin
      if (w_launchFire) begin
        r_launchPtr <= r_launchPtr + 1'b1;
      end
      for (int i = 0; i < PE_NUM; i++) begin
        if ((w_launchFire && (r_launchPtr == PE_IDX_W'(i))) &&
            !(w_popFire && (w_headPe == PE_IDX_W'(i)))) begin
          r_outstanding[i] <= r_outstanding[i] + 1'b1;
        end else if (!(w_launchFire && (r_launchPtr == PE_IDX_W'(i))) &&
                     (w_popFire && (w_headPe == PE_IDX_W'(i)))) begin
          r_outstanding[i] <= r_outstanding[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    idle = w_qEmpty;
    for (int i = 0; i < PE_NUM; i++) begin
      if (r_outstanding[i] != '0) begin
        idle = 1'b0;
      end
    end
  end

  assign jobs_in_flight = w_qCount;

endmodule

// File: tb/tb_match_pe_order_scheduler.sv
// Randomized and directed bench for the order scheduler against a queue-based model.
module tb_match_pe_order_scheduler;

  localparam int PE_NUM   = 4;
  localparam int SEQ_W    = 256;
  localparam int DEPTH    = 16;
  localparam int MAX_JOBS = 2;
  localparam int DEEP_MAX = 4;

  logic clk;
  logic rst;

  logic                    jobReqValid, jobReqDelim, jobReqReady;
  logic [PE_NUM-1:0]       peLaunchValid, peLaunchReady;
  logic                    peLaunchDelim;
  logic [PE_NUM-1:0]       seqInValid, seqInEoj, seqInReady;
  logic [PE_NUM*SEQ_W-1:0] seqInQuad;
  logic                    seqOutValid, seqOutDelim, seqOutReady;
  logic [SEQ_W-1:0]        seqOutQuad;
  logic [4:0]              jobsInFlight;
  logic                    idle;

  logic                    dJobReqValid, dJobReqDelim, dJobReqReady;
  logic [PE_NUM-1:0]       dPeLaunchValid, dPeLaunchReady;
  logic                    dPeLaunchDelim;
  logic [PE_NUM-1:0]       dSeqInValid, dSeqInEoj, dSeqInReady;
  logic [PE_NUM*SEQ_W-1:0] dSeqInQuad;
  logic                    dSeqOutValid, dSeqOutDelim, dSeqOutReady;
  logic [SEQ_W-1:0]        dSeqOutQuad;
  logic [4:0]              dJobsInFlight;
  logic                    dIdle;

  int assertCount;
  int failCount;

  typedef struct {
    int pe;
    bit delim;
  } entry_t;

  entry_t modelQ[$];
  int     modelOut[PE_NUM];
  int     modelPtr;

  int                mSel, mH;
  bit                mCan, mReady, mOutValid, mIdle;
  logic [PE_NUM-1:0] mLaunch, mInReady;

  match_pe_order_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .job_req_valid     (jobReqValid),
    .job_req_delim     (jobReqDelim),
    .job_req_ready     (jobReqReady),
    .pe_launch_valid   (peLaunchValid),
    .pe_launch_delim   (peLaunchDelim),
    .pe_launch_ready   (peLaunchReady),
    .seq_in_valid      (seqInValid),
    .seq_in_quad       (seqInQuad),
    .seq_in_end_of_job (seqInEoj),
    .seq_in_ready      (seqInReady),
    .seq_out_valid     (seqOutValid),
    .seq_out_quad      (seqOutQuad),
    .seq_out_delim     (seqOutDelim),
    .seq_out_ready     (seqOutReady),
    .jobs_in_flight    (jobsInFlight),
    .idle              (idle)
  );

  match_pe_order_scheduler #(.PE_MAX_JOBS(DEEP_MAX)) dutDeep (
    .clk               (clk),
    .rst               (rst),
    .job_req_valid     (dJobReqValid),
    .job_req_delim     (dJobReqDelim),
    .job_req_ready     (dJobReqReady),
    .pe_launch_valid   (dPeLaunchValid),
    .pe_launch_delim   (dPeLaunchDelim),
    .pe_launch_ready   (dPeLaunchReady),
    .seq_in_valid      (dSeqInValid),
    .seq_in_quad       (dSeqInQuad),
    .seq_in_end_of_job (dSeqInEoj),
    .seq_in_ready      (dSeqInReady),
    .seq_out_valid     (dSeqOutValid),
    .seq_out_quad      (dSeqOutQuad),
    .seq_out_delim     (dSeqOutDelim),
    .seq_out_ready     (dSeqOutReady),
    .jobs_in_flight    (dJobsInFlight),
    .idle              (dIdle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [SEQ_W-1:0] act,
                             input logic [SEQ_W-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PE_NUM-1:0] oneHot(input int i);
    logic [PE_NUM-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [SEQ_W-1:0] quadPat(input int pe, input int beat);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(pe * 16 + beat);
    return {8{w}};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    jobReqValid   = 1'b0;
    jobReqDelim   = 1'b0;
    peLaunchReady = '1;
    seqInValid    = '0;
    seqInEoj      = '0;
    seqInQuad     = '0;
    seqOutReady   = 1'b0;
    dJobReqValid   = 1'b0;
    dJobReqDelim   = 1'b0;
    dPeLaunchReady = '1;
    dSeqInValid    = '0;
    dSeqInEoj      = '0;
    dSeqInQuad     = '0;
    dSeqOutReady   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic launchJob(input logic delim, input int expPe);
    jobReqValid = 1'b1;
    jobReqDelim = delim;
    seqOutReady = 1'b0;
    @(negedge clk);
    checkOutput("launch_ready", jobReqReady, 1);
    checkOutput("launch_onehot", peLaunchValid, oneHot(expPe));
    nextCycle();
    jobReqValid = 1'b0;
  endtask

  task automatic applyStimulus();
    rst           = ($urandom_range(0, 199) == 0);
    jobReqValid   = ($urandom_range(0, 9) < 6);
    jobReqDelim   = $urandom_range(0, 1);
    peLaunchReady = PE_NUM'($urandom);
    seqInValid    = PE_NUM'($urandom | $urandom);
    seqInEoj      = PE_NUM'($urandom);
    seqOutReady   = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < PE_NUM * SEQ_W / 32; i++) begin
      seqInQuad[i*32 +: 32] = $urandom;
    end
  endtask

  // Reference behaviour: launch order queue plus per-PE outstanding counts.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_job_req_ready", jobReqReady, 0);
      checkOutput("rst_pe_launch_valid", peLaunchValid, 0);
      checkOutput("rst_seq_in_ready", seqInReady, 0);
      checkOutput("rst_seq_out_valid", seqOutValid, 0);
      modelQ.delete();
      for (int i = 0; i < PE_NUM; i++) modelOut[i] = 0;
      modelPtr = 0;
    end else begin
      mSel    = modelPtr;
      mCan    = (modelQ.size() < DEPTH) && (modelOut[mSel] < MAX_JOBS);
      mLaunch = '0;
      if (jobReqValid && mCan) mLaunch[mSel] = 1'b1;
      mReady  = mCan && peLaunchReady[mSel];
      mIdle   = (modelQ.size() == 0);
      for (int i = 0; i < PE_NUM; i++) if (modelOut[i] != 0) mIdle = 1'b0;
      checkOutput("pe_launch_valid", peLaunchValid, mLaunch);
      checkOutput("job_req_ready", jobReqReady, mReady);
      checkOutput("pe_launch_delim", peLaunchDelim, jobReqDelim);
      checkOutput("jobs_in_flight", jobsInFlight, modelQ.size());
      checkOutput("idle", idle, mIdle);
      mInReady  = '0;
      mOutValid = 1'b0;
      mH        = 0;
      if (modelQ.size() > 0) begin
        mH        = modelQ[0].pe;
        mOutValid = seqInValid[mH];
        if (seqOutReady) mInReady[mH] = 1'b1;
      end
      checkOutput("seq_out_valid", seqOutValid, mOutValid);
      checkOutput("seq_in_ready", seqInReady, mInReady);
      if (mOutValid) begin
        checkOutput("seq_out_quad", seqOutQuad, seqInQuad[mH*SEQ_W +: SEQ_W]);
        checkOutput("seq_out_delim", seqOutDelim, modelQ[0].delim && seqInEoj[mH]);
        if (seqOutReady && seqInEoj[mH]) begin
          modelOut[mH]--;
          void'(modelQ.pop_front());
        end
      end
      if (jobReqValid && mReady) begin
        modelQ.push_back('{pe: mSel, delim: jobReqDelim});
        modelOut[mSel]++;
        modelPtr = (modelPtr + 1) % PE_NUM;
      end
    end
  end

  initial begin
    int beat;
    assertCount = 0;
    failCount   = 0;
    modelPtr    = 0;
    for (int i = 0; i < PE_NUM; i++) modelOut[i] = 0;
    rst = 1'b1;
    idleInputs();
    nextCycle();
    nextCycle();
    rst = 1'b0;

    // Eight back-to-back jobs with sinks stalled, then the ninth is blocked.
    for (int i = 0; i < 8; i++) launchJob(1'b0, i % PE_NUM);
    jobReqValid = 1'b1;
    @(negedge clk);
    checkOutput("t1_in_flight", jobsInFlight, 8);
    checkOutput("t1_ninth_ready", jobReqReady, 0);
    checkOutput("t1_ninth_valid", peLaunchValid, 0);
    nextCycle();
    jobReqValid = 1'b0;

    // PE2 data arrives first but output stays in launch order.
    doReset();
    for (int i = 0; i < 4; i++) launchJob(1'b0, i);
    for (int i = 0; i < PE_NUM; i++) seqInQuad[i*SEQ_W +: SEQ_W] = quadPat(i, 0);
    seqOutReady = 1'b1;
    seqInEoj    = '1;
    seqInValid  = 4'b0100;
    @(negedge clk);
    checkOutput("t2_wait_valid", seqOutValid, 0);
    checkOutput("t2_wait_in_ready", seqInReady, 4'b0001);
    nextCycle();
    seqInValid = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t2_order_valid", seqOutValid, 1);
      checkOutput("t2_order_quad", seqOutQuad, quadPat(k, 0));
      checkOutput("t2_order_in_ready", seqInReady, oneHot(k));
      nextCycle();
    end
    @(negedge clk);
    checkOutput("t2_drained_idle", idle, 1);
    idleInputs();

    // Three-quad job on PE0 under a toggling sink, then a delim job on PE1.
    doReset();
    launchJob(1'b0, 0);
    launchJob(1'b1, 1);
    launchJob(1'b0, 2);
    beat       = 0;
    seqInValid = 4'b0011;
    seqInQuad[SEQ_W +: SEQ_W] = quadPat(1, 9);
    for (int k = 0; k < 5; k++) begin
      seqOutReady = (k % 2 == 0);
      seqInEoj    = (beat == 2) ? 4'b0001 : 4'b0000;
      seqInQuad[0 +: SEQ_W] = quadPat(0, beat);
      @(negedge clk);
      checkOutput("t3_valid", seqOutValid, 1);
      checkOutput("t3_quad", seqOutQuad, quadPat(0, beat));
      checkOutput("t3_in_ready", seqInReady, seqOutReady ? 4'b0001 : 4'b0000);
      checkOutput("t3_no_early_pop", jobsInFlight, 3);
      nextCycle();
      if (seqOutReady) beat++;
    end
    seqOutReady = 1'b1;
    seqInValid  = 4'b0010;
    seqInEoj    = 4'b0000;
    @(negedge clk);
    checkOutput("t3_popped", jobsInFlight, 2);
    checkOutput("t3_next_head", seqInReady, 4'b0010);
    checkOutput("t4_first_delim", seqOutDelim, 0);
    nextCycle();
    seqInEoj = 4'b0010;
    @(negedge clk);
    checkOutput("t4_last_delim", seqOutDelim, 1);
    nextCycle();
    seqInValid = 4'b0100;
    seqInEoj   = 4'b0100;
    @(negedge clk);
    checkOutput("t4_nodelim_valid", seqOutValid, 1);
    checkOutput("t4_nodelim_delim", seqOutDelim, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_empty", jobsInFlight, 0);
    idleInputs();

    // Full queue on the deep instance: simultaneous push and pop refuses the push.
    doReset();
    dJobReqValid = 1'b1;
    dSeqInQuad[0 +: SEQ_W] = quadPat(0, 5);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checkOutput("t5_fill_ready", dJobReqReady, 1);
      nextCycle();
    end
    dSeqOutReady = 1'b1;
    dSeqInValid  = 4'b0001;
    dSeqInEoj    = 4'b0001;
    @(negedge clk);
    checkOutput("t5_full_count", dJobsInFlight, 16);
    checkOutput("t5_full_refuse", dJobReqReady, 0);
    checkOutput("t5_full_no_launch", dPeLaunchValid, 0);
    checkOutput("t5_pop_valid", dSeqOutValid, 1);
    checkOutput("t5_pop_in_ready", dSeqInReady, 4'b0001);
    checkOutput("t5_pop_quad", dSeqOutQuad, quadPat(0, 5));
    checkOutput("t5_pop_delim", dSeqOutDelim, 0);
    checkOutput("t5_busy", dIdle, 0);
    nextCycle();
    dSeqOutReady = 1'b0;
    dSeqInValid  = '0;
    @(negedge clk);
    checkOutput("t5_after_pop", dJobsInFlight, 15);
    checkOutput("t5_retry_ready", dJobReqReady, 1);
    checkOutput("t5_retry_launch", dPeLaunchValid, 4'b0001);
    checkOutput("t5_launch_delim", dPeLaunchDelim, 0);
    nextCycle();
    dJobReqValid = 1'b0;
    @(negedge clk);
    checkOutput("t5_refilled", dJobsInFlight, 16);
    idleInputs();

    // Reset with five jobs in flight.
    doReset();
    for (int i = 0; i < 5; i++) launchJob(1'b0, i % PE_NUM);
    @(negedge clk);
    checkOutput("t6_in_flight", jobsInFlight, 5);
    rst         = 1'b1;
    jobReqValid = 1'b1;
    seqInValid  = '1;
    seqInEoj    = '1;
    seqOutReady = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_cleared", jobsInFlight, 0);
    checkOutput("t6_idle", idle, 1);
    checkOutput("t6_first_pe0", peLaunchValid, 4'b0001);
    nextCycle();

    // Randomized traffic, occasionally interrupted by reset.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      nextCycle();
    end
    rst = 1'b0;
    idleInputs();
    nextCycle();
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
